// File: rtl/commit_trace_sink.sv
// Commit-side trace sink: shadow register file, retired-instruction counter,
// HALT detection and a trace FIFO that drains over a valid/ready port.
module commit_trace_sink #(
  parameter int FIFO_DEPTH = 8,
  localparam int PTR_W = $clog2(FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit,
  input  logic [31:0] commit_pc,
  input  logic [31:0] commit_inst,
  input  logic        commit_halt,
  input  logic        commit_reg_we,
  input  logic [4:0]  commit_reg_wa,
  input  logic [31:0] commit_reg_wd,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_inst,
  output logic        trace_reg_we,
  output logic [4:0]  trace_reg_wa,
  output logic [31:0] trace_reg_wd,
  output logic        trace_halt,
  output logic        stall,
  output logic        overflow,
  output logic        halted,
  output logic [31:0] inst_count,
  input  logic [4:0]  shadow_ra,
  output logic [31:0] shadow_rd
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        reg_we;
    logic [4:0]  reg_wa;
    logic [31:0] reg_wd;
    logic        halt;
  } rec_t;

  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] STALL_CNT = (PTR_W+1)'(FIFO_DEPTH - 1);

  state_t           state;
  rec_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [31:0]      shadow [32];

  rec_t head;
  rec_t in_rec;
  logic accept;
  logic pop;
  logic push;

  // Trace port: a beat transfers on a rising edge where trace_valid && trace_ready;
  // the head record is held stable while trace_valid && !trace_ready.
  assign accept = (state == RUN) && commit;
  assign pop    = trace_valid && trace_ready;
  assign push   = accept && ((count < FULL_CNT) || pop);

  assign in_rec = '{pc: commit_pc, inst: commit_inst, reg_we: commit_reg_we,
                    reg_wa: commit_reg_wa, reg_wd: commit_reg_wd, halt: commit_halt};

  assign head         = mem[rd_ptr];
  assign trace_valid  = (count != '0);
  assign trace_pc     = head.pc;
  assign trace_inst   = head.inst;
  assign trace_reg_we = head.reg_we;
  assign trace_reg_wa = head.reg_wa;
  assign trace_reg_wd = head.reg_wd;
  assign trace_halt   = head.halt;

  // One slot of margin covers the record already sitting in the core's commit register.
  assign stall     = (count >= STALL_CNT);
  assign halted    = (state == HALTED);
  assign shadow_rd = shadow[shadow_ra];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      inst_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      for (int i = 0; i < 32; i++) shadow[i] <= '0;
    end else begin
      case (state)
        RUN:     if (accept && commit_halt) state <= HALTED;
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase

      if (accept) inst_count <= inst_count + 32'd1;
      if (accept && commit_reg_we && (commit_reg_wa != 5'd0))
        shadow[commit_reg_wa] <= commit_reg_wd;

      if (push) begin
        mem[wr_ptr] <= in_rec;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);

      // Architectural state above still updates; only the trace record is lost.
      if (accept && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_commit_trace_sink.sv
// Self-checking bench for commit_trace_sink: reference model plus a scoreboard
// of expected trace records, one task per scenario.
`timescale 1ns/1ps
module tb_commit_trace_sink;

  localparam int FIFO_DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        commit;
  logic [31:0] commit_pc;
  logic [31:0] commit_inst;
  logic        commit_halt;
  logic        commit_reg_we;
  logic [4:0]  commit_reg_wa;
  logic [31:0] commit_reg_wd;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_inst;
  logic        trace_reg_we;
  logic [4:0]  trace_reg_wa;
  logic [31:0] trace_reg_wd;
  logic        trace_halt;
  logic        stall;
  logic        overflow;
  logic        halted;
  logic [31:0] inst_count;
  logic [4:0]  shadow_ra;
  logic [31:0] shadow_rd;

  commit_trace_sink #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .commit(commit), .commit_pc(commit_pc),
    .commit_inst(commit_inst), .commit_halt(commit_halt),
    .commit_reg_we(commit_reg_we), .commit_reg_wa(commit_reg_wa),
    .commit_reg_wd(commit_reg_wd), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_pc(trace_pc), .trace_inst(trace_inst),
    .trace_reg_we(trace_reg_we), .trace_reg_wa(trace_reg_wa),
    .trace_reg_wd(trace_reg_wd), .trace_halt(trace_halt), .stall(stall),
    .overflow(overflow), .halted(halted), .inst_count(inst_count),
    .shadow_ra(shadow_ra), .shadow_rd(shadow_rd)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  // Scoreboard and reference model
  logic [102:0] exp_q[$];
  int           checks;
  int           failures;
  int           m_count;
  logic         m_halted;
  logic         m_overflow;
  logic [31:0]  m_inst;
  logic [31:0]  m_shadow [32];
  int           n_beats;
  logic         last_halt;

  task automatic model_clear();
    exp_q.delete();
    m_count    = 0;
    m_halted   = 1'b0;
    m_overflow = 1'b0;
    m_inst     = 32'd0;
    for (int i = 0; i < 32; i++) m_shadow[i] = 32'd0;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    commit        = 1'b0;
    commit_pc     = 32'd0;
    commit_inst   = 32'd0;
    commit_halt   = 1'b0;
    commit_reg_we = 1'b0;
    commit_reg_wa = 5'd0;
    commit_reg_wd = 32'd0;
    trace_ready   = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_clear();
  endtask

  // Drives one cycle; entered and left at 1ns after a rising edge.
  task automatic cycle(input logic c, input logic [31:0] pc, input logic [31:0] inst,
                       input logic h, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic rdy);
    logic         acc, pop, push;
    logic [102:0] got, exp;
    commit = c; commit_pc = pc; commit_inst = inst; commit_halt = h;
    commit_reg_we = we; commit_reg_wa = wa; commit_reg_wd = wd; trace_ready = rdy;
    #2;
    checks++;
    if (trace_valid !== (m_count != 0)) begin
      failures++;
      $display("FAIL trace_valid got=%b exp=%b", trace_valid, (m_count != 0));
    end
    acc  = c && !m_halted;
    pop  = (m_count != 0) && rdy;
    push = acc && ((m_count < FIFO_DEPTH) || pop);
    if (pop) begin
      got = {trace_pc, trace_inst, trace_reg_we, trace_reg_wa, trace_reg_wd, trace_halt};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL trace_beat got=%h exp=<none queued>", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL trace_beat got=%h exp=%h", got, exp);
        end
      end
      n_beats++;
      last_halt = trace_halt;
    end
    if (push) exp_q.push_back({pc, inst, we, wa, wd, h});
    if (acc && !push) m_overflow = 1'b1;
    if (acc) m_inst = m_inst + 32'd1;
    if (acc && we && (wa != 5'd0)) m_shadow[wa] = wd;
    if (acc && h) m_halted = 1'b1;
    if (push && !pop) m_count++;
    else if (pop && !push) m_count--;
    @(posedge clk); #1;
    checks++;
    if ({stall, overflow, halted, inst_count} !== {(m_count >= FIFO_DEPTH - 1), m_overflow, m_halted, m_inst}) begin
      failures++;
      $display("FAIL status stall/ovf/halted/count got=%b/%b/%b/%0d exp=%b/%b/%b/%0d",
               stall, overflow, halted, inst_count,
               (m_count >= FIFO_DEPTH - 1), m_overflow, m_halted, m_inst);
    end
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && m_count == 0) break;
      idle(1'b1);
    end
    checks++;
    if (exp_q.size() != 0 || trace_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_timeout left=%0d trace_valid=%b exp=0/0", exp_q.size(), trace_valid);
    end
  endtask

  // Compares every shadow register against the model; realigns to the clock after.
  task automatic check_shadow(input string tag);
    commit = 1'b0;
    trace_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      shadow_ra = 5'(i);
      #0.2;
      checks++;
      if (shadow_rd !== m_shadow[i]) begin
        failures++;
        $display("FAIL %s shadow r%0d got=%h exp=%h", tag, i, shadow_rd, m_shadow[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({trace_valid, stall, overflow, halted} !== 4'b0000 || inst_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_status got=%b%b%b%b count=%0d exp=0000 count=0",
               trace_valid, stall, overflow, halted, inst_count);
    end
    checks++;
    if ({trace_pc, trace_inst, trace_reg_we, trace_reg_wa, trace_reg_wd, trace_halt} !== 103'd0) begin
      failures++;
      $display("FAIL reset_trace_fields got pc=%h inst=%h exp=0", trace_pc, trace_inst);
    end
    check_shadow("reset");
  endtask

  task automatic test_basic();
    do_reset();
    n_beats = 0;
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h1c00_0000 + 32'(4 * i), 32'h0000_1000 + 32'(i), 1'b0, 1'b1,
            5'(i + 1), 32'(5 + i), 1'b1);
    drain();
    checks++;
    if (n_beats != 3 || inst_count !== 32'd3) begin
      failures++;
      $display("FAIL basic beats/count got=%0d/%0d exp=3/3", n_beats, inst_count);
    end
    m_shadow[1] = 32'd5; m_shadow[2] = 32'd6; m_shadow[3] = 32'd7;
    check_shadow("basic");
  endtask

  task automatic test_r0_write();
    cycle(1'b1, 32'h1c00_0010, 32'h0000_2000, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0);
    shadow_ra = 5'd0;
    #0.2;
    checks++;
    if (shadow_rd !== 32'd0) begin
      failures++;
      $display("FAIL r0_write shadow r0 got=%h exp=00000000", shadow_rd);
    end
    checks++;
    if (trace_valid !== 1'b1 || trace_reg_wa !== 5'd0 || trace_reg_wd !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL r0_trace got=%b/%0d/%h exp=1/0/deadbeef", trace_valid, trace_reg_wa, trace_reg_wd);
    end
    drain();
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 32'h2000_0000 + 32'(4 * i), 32'h0000_3000 + 32'(i), 1'b0, 1'b1,
            5'(10 + i), 32'h100 + 32'(i), 1'b0);
      if (i == 5) begin
        checks++;
        if (stall !== 1'b0) begin
          failures++;
          $display("FAIL stall_at_6 got=%b exp=0", stall);
        end
      end
      if (i == 6 || i == 7) begin
        checks++;
        if (stall !== 1'b1 || overflow !== 1'b0) begin
          failures++;
          $display("FAIL stall_near_full i=%0d stall/ovf got=%b/%b exp=1/0", i, stall, overflow);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || inst_count !== 32'd9) begin
      failures++;
      $display("FAIL overflow ovf/count got=%b/%0d exp=1/9", overflow, inst_count);
    end
    n_beats = 0;
    drain();
    checks++;
    if (n_beats != 8 || stall !== 1'b0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_drain beats/stall/ovf got=%0d/%b/%b exp=8/0/1", n_beats, stall, overflow);
    end
    check_shadow("overflow");
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 32'h3000_0000 + 32'(4 * i), 32'h0000_4000 + 32'(i), 1'b0, 1'b0,
            5'd0, 32'd0, 1'b0);
    cycle(1'b1, 32'h3000_0100, 32'h0000_4100, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    checks++;
    if (overflow !== 1'b0 || stall !== 1'b1) begin
      failures++;
      $display("FAIL full_push_pop ovf/stall got=%b/%b exp=0/1", overflow, stall);
    end
    // Occupancy must still be full, so a further commit without a pop is dropped.
    cycle(1'b1, 32'h3000_0200, 32'h0000_4200, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL full_still_full ovf got=%b exp=1", overflow);
    end
    n_beats = 0;
    drain();
    checks++;
    if (n_beats != 8) begin
      failures++;
      $display("FAIL full_drain beats got=%0d exp=8", n_beats);
    end
  endtask

  task automatic test_halt();
    do_reset();
    cycle(1'b1, 32'h1c00_0040, 32'h8000_0000, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    checks++;
    if (halted !== 1'b1 || inst_count !== 32'd1) begin
      failures++;
      $display("FAIL halt halted/count got=%b/%0d exp=1/1", halted, inst_count);
    end
    cycle(1'b1, 32'h1c00_0044, 32'h0000_5000, 1'b0, 1'b1, 5'd9, 32'h1234_5678, 1'b0);
    cycle(1'b1, 32'h1c00_0048, 32'h0000_5001, 1'b0, 1'b1, 5'd9, 32'h8765_4321, 1'b0);
    checks++;
    if (inst_count !== 32'd1 || halted !== 1'b1) begin
      failures++;
      $display("FAIL after_halt count/halted got=%0d/%b exp=1/1", inst_count, halted);
    end
    n_beats = 0;
    last_halt = 1'b0;
    drain();
    checks++;
    if (n_beats != 1 || last_halt !== 1'b1) begin
      failures++;
      $display("FAIL halt_drain beats/halt got=%0d/%b exp=1/1", n_beats, last_halt);
    end
    check_shadow("halt");
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 32'h4000_0000 + 32'(4 * i), (i == 4) ? 32'h8000_0000 : 32'(i),
            (i == 4), 1'b1, 5'(20 + i), 32'hA000 + 32'(i), 1'b0);
    idle(1'b1);
    do_reset();
    checks++;
    if ({trace_valid, overflow, halted, stall} !== 4'b0000 || inst_count !== 32'd0) begin
      failures++;
      $display("FAIL mid_drain_reset valid/ovf/halted/stall got=%b%b%b%b count=%0d exp=0000 count=0",
               trace_valid, overflow, halted, stall, inst_count);
    end
    check_shadow("mid_drain_reset");
    cycle(1'b1, 32'h4000_0100, 32'h0000_6000, 1'b0, 1'b1, 5'd4, 32'h44, 1'b0);
    n_beats = 0;
    drain();
    checks++;
    if (n_beats != 1) begin
      failures++;
      $display("FAIL post_reset_beats got=%0d exp=1", n_beats);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 80; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 3) != 0));
    drain();
    check_shadow("back_to_back");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    n_beats = 0;
    last_halt = 1'b0;
    shadow_ra = 5'd0;
    model_clear();
    do_reset();
    test_reset();
    test_basic();
    test_r0_write();
    test_overflow();
    test_full_push_pop();
    test_halt();
    test_reset_mid_drain();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
